// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier: one add/sub + arithmetic shift per clock,
// start/busy/done handshake, product held until the next accepted start.
module booth_mult_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int E  = WIDTH + 1;
  localparam int CW = $clog2(E + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [E:0]         a_reg, m_reg;
  logic [E-1:0]       q_reg;
  logic               qm1_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] product_reg;
  logic               busy_reg, done_reg;

  logic               load, step, finish;
  logic [E:0]         m_ext;
  logic [E-1:0]       q_ext;
  logic [E:0]         a_sum, a_shift;
  logic [E-1:0]       q_shift;
  logic               qm1_shift;

  // One extra sign bit beyond the E-bit operands keeps the most-negative cases exact.
  always_comb begin
    m_ext = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                        : {2'b00, multiplicand};
    q_ext = signed_mode ? {multiplier[WIDTH-1], multiplier}
                        : {1'b0, multiplier};
  end

  always_comb begin
    a_sum = a_reg;
    case ({q_reg[0], qm1_reg})
      2'b01:   a_sum = a_reg + m_reg;
      2'b10:   a_sum = a_reg - m_reg;
      default: a_sum = a_reg;
    endcase
    a_shift   = {a_sum[E], a_sum[E:1]};
    q_shift   = {a_sum[0], q_reg[E-1:1]};
    qm1_shift = q_reg[0];
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_reg == CW'(1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      m_reg       <= '0;
      q_reg       <= '0;
      qm1_reg     <= 1'b0;
      cnt_reg     <= '0;
      product_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == RUN);
      done_reg  <= (state_next == DONE);
      if (load) begin
        m_reg   <= m_ext;
        a_reg   <= '0;
        q_reg   <= q_ext;
        qm1_reg <= 1'b0;
        cnt_reg <= CW'(E);
      end else if (step) begin
        a_reg   <= a_shift;
        q_reg   <= q_shift;
        qm1_reg <= qm1_shift;
        cnt_reg <= cnt_reg - CW'(1);
      end
      // Product only updates on the final step, so it never glitches mid-operation.
      if (finish) product_reg <= {a_shift[WIDTH-2:0], q_shift};
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomised checks of booth_mult_seq at WIDTH=4 and WIDTH=8.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic start4, sm4, busy4, done4;
  logic [3:0] m4, q4;
  logic [7:0] p4;
  logic start8, sm8, busy8, done8;
  logic [7:0] m8, q8;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .multiplicand(m4), .multiplier(q4), .busy(busy4), .done(done4), .product(p4)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .multiplicand(m8), .multiplier(q8), .busy(busy8), .done(done8), .product(p8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one WIDTH=4 operation, checking latency, busy length, handshake and product.
  task automatic run4(input string tag, input logic sm, input logic [3:0] m,
                      input logic [3:0] q, input logic [7:0] exp);
    int n;
    int bn;
    start4 = 1'b1; sm4 = sm; m4 = m; q4 = q;
    tick();
    start4 = 1'b0; m4 = 4'($urandom); q4 = 4'($urandom); sm4 = ~sm;
    n = 0; bn = 0;
    while (!done4 && n < 20) begin
      if (busy4) bn++;
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 5);
    chk({tag, "_busy_cycles"}, bn, 5);
    chk({tag, "_busy_at_done"}, 32'(busy4), 0);
    chk({tag, "_product"}, 32'(p4), 32'(exp));
    $display("op %s sm=%0d m=%h q=%h product=%h", tag, sm, m, q, p4);
    tick();
    chk({tag, "_done_pulse"}, 32'(done4), 0);
    chk({tag, "_held"}, 32'(p4), 32'(exp));
  endtask

  task automatic run8(input int idx, input logic sm, input logic [7:0] m, input logic [7:0] q);
    int n;
    logic signed [15:0] ps;
    logic [15:0] exp;
    ps  = $signed(m) * $signed(q);
    exp = sm ? ps : (16'(m) * 16'(q));
    start8 = 1'b1; sm8 = sm; m8 = m; q8 = q;
    tick();
    start8 = 1'b0; m8 = 8'($urandom); q8 = 8'($urandom);
    n = 0;
    while (!done8 && n < 30) begin
      tick();
      n++;
    end
    chk("w8_latency", n, 9);
    chk("w8_product", 32'(p8), 32'(exp));
    if (idx % 100 == 0)
      $display("op w8 #%0d sm=%0d m=%h q=%h product=%h", idx, sm, m, q, p8);
    tick();
  endtask

  initial begin
    int n;
    int dn;
    rst_n = 1'b0;
    start4 = 1'b0; sm4 = 1'b0; m4 = '0; q4 = '0;
    start8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;
    tick(); tick();
    chk("rst_busy4", 32'(busy4), 0);
    chk("rst_done4", 32'(done4), 0);
    chk("rst_product4", 32'(p4), 0);
    chk("rst_product8", 32'(p8), 0);
    rst_n = 1'b1;
    tick();

    run4("s_3xm2",   1'b1, 4'h3, 4'hE, 8'hFA);
    run4("s_m8xm8",  1'b1, 4'h8, 4'h8, 8'h40);
    run4("u_15x15",  1'b0, 4'hF, 4'hF, 8'hE1);
    run4("u_8x3",    1'b0, 4'h8, 4'h3, 8'h18);
    run4("s_8x3",    1'b1, 4'h8, 4'h3, 8'hE8);
    run4("s_7xm8",   1'b1, 4'h7, 4'h8, 8'hC8);
    run4("u_0x9",    1'b0, 4'h0, 4'h9, 8'h00);
    run4("s_m1xm1",  1'b1, 4'hF, 4'hF, 8'h01);

    // start held high through RUN while operands keep changing
    start4 = 1'b1; sm4 = 1'b1; m4 = 4'h3; q4 = 4'hE;
    tick();
    n = 0;
    while (!done4 && n < 20) begin
      m4 = 4'($urandom); q4 = 4'($urandom); sm4 = 1'($urandom);
      tick();
      n++;
    end
    start4 = 1'b0;
    chk("held_latency", n, 5);
    chk("held_product", 32'(p4), 32'hFA);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done4) dn++;
    end
    chk("held_extra_done", dn, 0);
    $display("op held_start product=%h", p4);

    // reset during the third RUN cycle aborts the operation
    start4 = 1'b1; sm4 = 1'b1; m4 = 4'h8; q4 = 4'h8;
    tick();
    start4 = 1'b0;
    tick(); tick();
    chk("abort_busy_before", 32'(busy4), 1);
    rst_n = 1'b0;
    tick();
    chk("abort_busy", 32'(busy4), 0);
    chk("abort_done", 32'(done4), 0);
    chk("abort_product", 32'(p4), 0);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done4 || busy4) dn++;
    end
    chk("abort_no_done", dn, 0);
    $display("op abort product=%h", p4);

    for (int i = 0; i < 1000; i++)
      run8(i, 1'($urandom), 8'($urandom), 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
